// File: rtl/record_arbiter.sv
// Round-robin arbiter between two record requesters; serves one record at a time
// and presents x + y of the served record with its source id to a single consumer.
package record_arbiter_pkg;
   typedef struct packed {
      logic signed [31:0] x;
      logic        [31:0] y;
   } record_t;
endpackage

module record_arbiter
   import record_arbiter_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  record_t          a_in,
   input  logic             a_in_sync,
   output logic             a_in_notify,
   input  record_t          b_in,
   input  logic             b_in_sync,
   output logic             b_in_notify,
   output logic [31:0]      res_out,
   output logic             res_id,
   input  logic             res_out_sync,
   output logic             res_out_notify,
   output logic [CNT_W-1:0] a_cnt,
   output logic [CNT_W-1:0] b_cnt
);

   typedef enum logic [1:0] {
      POLL_A,
      POLL_B,
      SEND
   } state_t;

   state_t state;

   // Notifies are registered alongside the state, so a transfer is simply notify && sync.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= POLL_A;
         a_in_notify    <= 1'b1;
         b_in_notify    <= 1'b0;
         res_out_notify <= 1'b0;
         res_out        <= '0;
         res_id         <= 1'b0;
         a_cnt          <= '0;
         b_cnt          <= '0;
      end else begin
         case (state)
            POLL_A: begin
               a_in_notify <= 1'b0;
               if (a_in_notify && a_in_sync) begin
                  res_out        <= unsigned'(a_in.x) + a_in.y;
                  res_id         <= 1'b0;
                  res_out_notify <= 1'b1;
                  if (a_cnt != '1) a_cnt <= a_cnt + CNT_W'(1);
                  state          <= SEND;
               end else begin
                  b_in_notify <= 1'b1;
                  state       <= POLL_B;
               end
            end
            POLL_B: begin
               b_in_notify <= 1'b0;
               if (b_in_notify && b_in_sync) begin
                  res_out        <= unsigned'(b_in.x) + b_in.y;
                  res_id         <= 1'b1;
                  res_out_notify <= 1'b1;
                  if (b_cnt != '1) b_cnt <= b_cnt + CNT_W'(1);
                  state          <= SEND;
               end else begin
                  a_in_notify <= 1'b1;
                  state       <= POLL_A;
               end
            end
            SEND: begin
               // Hand the next poll to the requester that was not just served.
               if (res_out_notify && res_out_sync) begin
                  res_out_notify <= 1'b0;
                  if (res_id) begin
                     a_in_notify <= 1'b1;
                     state       <= POLL_A;
                  end else begin
                     b_in_notify <= 1'b1;
                     state       <= POLL_B;
                  end
               end
            end
            default: begin
               state          <= POLL_A;
               a_in_notify    <= 1'b1;
               b_in_notify    <= 1'b0;
               res_out_notify <= 1'b0;
            end
         endcase
      end
   end

endmodule
